// File: rtl/rv32_mon_pkg.sv
// Shared types for the RV32 commit monitor: FSM states and the trace entry layout.
package rv32_mon_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } trace_entry_t;
endpackage

// File: rtl/rv32_trace_fifo.sv
// Show-ahead synchronous FIFO: the head entry is presented whenever valid is high,
// and a push into a full FIFO is accepted only if a pop happens on the same edge.
module rv32_trace_fifo
  import rv32_mon_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = trace_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   din,
  input  logic                     pop,
  output entry_t                   dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign valid = (count_q != '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  assign dout  = valid ? mem_q[rd_ptr_q] : '0;
endmodule

// File: rtl/rv32_commit_monitor.sv
// Watches the core's write-back stream, logs register writes into a trace FIFO
// and declares end of program on a PC self-loop or a cycle timeout.
module rv32_commit_monitor
  import rv32_mon_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int HALT_CYC = 4,
  parameter int MAX_CYC  = 100000,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      cur_pcout,
  input  logic             reg_wen,
  input  logic [4:0]       rd_adr,
  input  logic [31:0]      rddata,
  output logic             trc_valid,
  input  logic             trc_ready,
  output logic [31:0]      trc_pc,
  output logic [4:0]       trc_rd,
  output logic [31:0]      trc_data,
  output logic             stop_en,
  output logic             timeout,
  output logic             ovf,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);
  localparam int ST_W = (HALT_CYC > 2) ? $clog2(HALT_CYC) : 1;
  localparam logic [ST_W-1:0]  HALT_STALL = ST_W'(HALT_CYC - 2);
  localparam logic             TO_EN      = (MAX_CYC != 0);
  localparam logic [CNT_W-1:0] TO_CNT     = CNT_W'(MAX_CYC - 1);

  mon_state_e       state_q, state_d;
  logic [31:0]      prev_pc_q, prev_pc_d;
  logic             prev_ok_q, prev_ok_d;
  logic [ST_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic             stop_q, stop_d;
  logic             timeout_q, timeout_d;
  logic             ovf_q, ovf_d;

  logic             push_req, pop_fire, fifo_full, same_pc, halt, tmo;
  logic [$clog2(DEPTH):0] fifo_cnt_unused;
  trace_entry_t     entry_in, head;

  assign push_req = (state_q == RUN) && reg_wen && (rd_adr != 5'd0);
  assign pop_fire = trc_valid && trc_ready;
  // prev_ok_q is low on the first RUN cycle, when prev_pc has not been sampled yet.
  assign same_pc  = prev_ok_q && (cur_pcout == prev_pc_q);
  assign halt     = same_pc && (stall_q == HALT_STALL);
  assign tmo      = TO_EN && (cycle_q == TO_CNT);
  assign entry_in = '{pc: cur_pcout, rd: rd_adr, data: rddata};

  always_comb begin
    state_d   = state_q;
    prev_pc_d = prev_pc_q;
    prev_ok_d = prev_ok_q;
    stall_d   = stall_q;
    cycle_d   = cycle_q;
    retire_d  = retire_q;
    stop_d    = stop_q;
    timeout_d = timeout_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          prev_ok_d = 1'b0;
          stall_d   = '0;
        end
      end
      RUN: begin
        if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
        prev_pc_d = cur_pcout;
        prev_ok_d = 1'b1;
        stall_d   = same_pc ? stall_q + ST_W'(1) : '0;
        if (push_req) begin
          if (retire_q != '1) retire_d = retire_q + CNT_W'(1);
          if (fifo_full && !pop_fire) ovf_d = 1'b1;
        end
        if (halt || tmo) begin
          state_d   = STOP;
          stop_d    = 1'b1;
          timeout_d = !halt;
        end
      end
      STOP:    state_d = STOP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      prev_pc_q <= '0;
      prev_ok_q <= 1'b0;
      stall_q   <= '0;
      cycle_q   <= '0;
      retire_q  <= '0;
      stop_q    <= 1'b0;
      timeout_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_pc_q <= prev_pc_d;
      prev_ok_q <= prev_ok_d;
      stall_q   <= stall_d;
      cycle_q   <= cycle_d;
      retire_q  <= retire_d;
      stop_q    <= stop_d;
      timeout_q <= timeout_d;
      ovf_q     <= ovf_d;
    end
  end

  rv32_trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (trace_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (entry_in),
    .pop   (trc_ready),
    .dout  (head),
    .valid (trc_valid),
    .full  (fifo_full),
    .count (fifo_cnt_unused)
  );

  assign trc_pc     = head.pc;
  assign trc_rd     = head.rd;
  assign trc_data   = head.data;
  assign stop_en    = stop_q;
  assign timeout    = timeout_q;
  assign ovf        = ovf_q;
  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
endmodule

// File: tb/tb_rv32_commit_monitor.sv
// Bench for rv32_commit_monitor: directed and random episodes compared every cycle
// against a queue-based reference model of the monitor.
module tb_rv32_commit_monitor;
  localparam int DEPTH = 4, HALT_CYC = 4, MAX_CYC = 20, CNT_W = 32;

  logic clk = 1'b0;
  logic rst, start, reg_wen, trc_ready;
  logic [31:0] cur_pcout, rddata;
  logic [4:0]  rd_adr;
  logic trc_valid, stop_en, timeout, ovf;
  logic [31:0] trc_pc, trc_data;
  logic [4:0]  trc_rd;
  logic [CNT_W-1:0] cycle_cnt, retire_cnt;

  rv32_commit_monitor #(.DEPTH(DEPTH), .HALT_CYC(HALT_CYC), .MAX_CYC(MAX_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cur_pcout(cur_pcout), .reg_wen(reg_wen),
    .rd_adr(rd_adr), .rddata(rddata), .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_pc(trc_pc), .trc_rd(trc_rd), .trc_data(trc_data), .stop_en(stop_en),
    .timeout(timeout), .ovf(ovf), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 run, 2 stop; run_len counts equal PC samples in a row.
  typedef struct { logic [31:0] pc; logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t q[$];
  int m_state, m_cycles, m_retire, m_run_len;
  bit m_stop, m_to, m_ovf;
  logic [31:0] m_prev;

  task automatic model_reset();
    q.delete();
    m_state = 0; m_cycles = 0; m_retire = 0; m_run_len = 0;
    m_stop = 0; m_to = 0; m_ovf = 0; m_prev = '0;
  endtask

  task automatic model_edge();
    int sz = q.size();
    bit pop = (sz > 0) && trc_ready;
    bit push = (m_state == 1) && reg_wen && (rd_adr != 0);
    if (pop) void'(q.pop_front());
    if (push) begin
      m_retire++;
      if (sz < DEPTH || pop) q.push_back('{cur_pcout, rd_adr, rddata});
      else m_ovf = 1;
    end
    case (m_state)
      0: if (start) begin m_state = 1; m_run_len = 0; end
      1: begin
        m_cycles++;
        m_run_len = (m_run_len > 0 && cur_pcout == m_prev) ? m_run_len + 1 : 1;
        m_prev = cur_pcout;
        if (m_run_len >= HALT_CYC) begin
          m_state = 2; m_stop = 1;
        end else if (MAX_CYC != 0 && m_cycles == MAX_CYC) begin
          m_state = 2; m_stop = 1; m_to = 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic cmp_all(input string tag);
    bit v = q.size() > 0;
    check({tag, ".valid"}, trc_valid, v);
    check({tag, ".pc"},    trc_pc,    v ? q[0].pc : 32'd0);
    check({tag, ".rd"},    trc_rd,    v ? q[0].rd : 5'd0);
    check({tag, ".data"},  trc_data,  v ? q[0].d  : 32'd0);
    check({tag, ".stop"},  stop_en,   m_stop);
    check({tag, ".tmo"},   timeout,   m_to);
    check({tag, ".ovf"},   ovf,       m_ovf);
    check({tag, ".cyc"},   cycle_cnt, m_cycles);
    check({tag, ".ret"},   retire_cnt, m_retire);
  endtask

  task automatic cyc(input string tag, input logic st, input logic [31:0] pc, input logic wen,
                     input logic [4:0] rd, input logic [31:0] d, input logic rdy);
    start = st; cur_pcout = pc; reg_wen = wen; rd_adr = rd; rddata = d; trc_ready = rdy;
    @(posedge clk);
    model_edge();
    #1 cmp_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; start = 0; reg_wen = 0; rd_adr = 0; rddata = 0; trc_ready = 0; cur_pcout = 0;
    model_reset();
    @(posedge clk);
    #1 cmp_all(tag);
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    rst = 1'b0; start = 0; reg_wen = 0; rd_adr = 0; rddata = 0; trc_ready = 0; cur_pcout = 0;
    #2;

    // Idle: writes without start are never logged
    do_reset("rst0");
    for (int i = 0; i < 5; i++) cyc("idle", 0, 32'h100, 1, 5'd5, 32'hdead, 1);
    check("idle_valid", trc_valid, 0);
    check("idle_retire", retire_cnt, 0);

    // Log/drain then halt on a self-loop at PC 12
    do_reset("rst1");
    cyc("ld", 1, 0, 0, 0, 0, 1);
    cyc("ld", 0, 0, 1, 5'd1, 10, 1);
    cyc("ld", 0, 4, 1, 5'd2, 20, 1);
    cyc("ld", 0, 8, 1, 5'd0, 99, 1);
    check("ld_retire", retire_cnt, 2);
    for (int i = 0; i < 3; i++) cyc("halt", 0, 12, 0, 0, 0, 1);
    check("halt_not_yet", stop_en, 0);
    cyc("halt", 0, 12, 0, 0, 0, 1);
    check("halt_stop", stop_en, 1);
    check("halt_tmo", timeout, 0);
    cyc("halt_start", 1, 16, 1, 5'd3, 7, 1);
    check("halt_start_ign", stop_en, 1);

    // Timeout with a steadily advancing PC
    do_reset("rst2");
    cyc("to", 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 24; i++)
      cyc("to", 0, 32'h1000 + 4 * i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 1);
    check("to_flag", timeout, 1);
    check("to_cycles", cycle_cnt, 20);

    // Overflow: six writes into a four-entry FIFO, then drain
    do_reset("rst3");
    cyc("ov", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc("ov", 0, 32'h200 + 4 * i, 1, 5'(i + 1), 32'(i * 11), 0);
    check("ov_flag", ovf, 1);
    check("ov_retire", retire_cnt, 6);
    check("ov_head_pc", trc_pc, 32'h200);
    for (int i = 0; i < 5; i++) cyc("ov_drain", 0, 32'h300 + 4 * i, 0, 0, 0, 1);
    check("ov_empty", trc_valid, 0);

    // Full FIFO with simultaneous push and pop drops nothing
    do_reset("rst4");
    cyc("fp", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("fp", 0, 32'h400 + 4 * i, 1, 5'(i + 1), 32'(100 + i), 0);
    cyc("fp_both", 0, 32'h410, 1, 5'd9, 32'h55, 1);
    check("fp_no_ovf", ovf, 0);
    for (int i = 0; i < 4; i++) cyc("fp_drain", 0, 32'h500 + 4 * i, 0, 0, 0, 1);
    check("fp_drained", trc_valid, 0);

    // Asynchronous reset with entries queued mid-run
    do_reset("rst5");
    cyc("ar", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("ar", 0, 32'h600 + 4 * i, 1, 5'(i + 4), $urandom, 0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("ar_valid", trc_valid, 0);
    check("ar_cyc", cycle_cnt, 0);
    check("ar_ret", retire_cnt, 0);
    cmp_all("ar");
    @(negedge clk) rst = 1'b0;

    // Random episodes
    for (int e = 0; e < 30; e++) begin
      int rst_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(3, 30)) : -1;
      do_reset("rnd_rst");
      pc = $urandom & 32'hfffc;
      for (int k = 0; k < 40; k++) begin
        int r = $urandom_range(0, 9);
        if (k > 0) pc = (r < 6) ? pc + 4 : (r < 9) ? pc : ($urandom & 32'hfffc);
        cyc("rnd", (k == 0) || ($urandom_range(0, 19) == 0), pc, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 2) != 0));
        if (k == rst_at) begin
          #2 rst = 1'b1;
          model_reset();
          #1 cmp_all("rnd_async");
          @(negedge clk) rst = 1'b0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rv32_commit_monitor.md
Name: rv32_commit_monitor

Overview:
- Sits directly downstream of the RV32 core and consumes its per-cycle debug outputs: current PC, rd address, rd write data and register write enable.
- Records every architectural register write into a trace FIFO that a bench or debug port drains through a valid/ready interface.
- Detects end of program, either a PC self-loop or a cycle timeout, and asserts stop_en.
- Replaces hand-timed stop logic in simulation and gives FPGA debug a bounded commit log.

Parameters:
- DEPTH, 16: trace FIFO entries; power of two, minimum 2.
- HALT_CYC, 4: consecutive cycles of unchanged PC that declare a halt; minimum 2.
- MAX_CYC, 100000: cycle timeout in RUN; 0 disables the timeout.
- CNT_W, 32: width of the cycle and retire counters.

Ports:
- clk, in, 1: core clock.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle pulse that begins monitoring; ignored outside IDLE.
- cur_pcout, in, 32: PC of the instruction executing this cycle.
- reg_wen, in, 1: core register-file write enable.
- rd_adr, in, 5: destination register.
- rddata, in, 32: write-back data.
- trc_valid, out, 1: FIFO head entry is valid.
- trc_ready, in, 1: consumer accepts the head entry.
- trc_pc, out, 32: PC of the head entry.
- trc_rd, out, 5: rd of the head entry.
- trc_data, out, 32: data of the head entry.
- stop_en, out, 1: program finished (halt or timeout); registered.
- timeout, out, 1: stop was caused by MAX_CYC.
- ovf, out, 1: sticky flag, at least one write was dropped because the FIFO was full.
- cycle_cnt, out, CNT_W: cycles spent in RUN.
- retire_cnt, out, CNT_W: logged writes, including dropped ones.

Behaviour:
- Reset (async, rst=1):
  - State returns to IDLE.
  - FIFO is emptied: pointers 0, trc_valid=0.
  - trc_pc, trc_rd, trc_data drive 0 when empty.
  - stop_en, timeout and ovf are 0.
  - cycle_cnt and retire_cnt are 0.
  - prev_pc is 0 and the stall counter is 0.
- FSM states IDLE, RUN, STOP:
  - IDLE -> RUN on start=1.
  - RUN -> STOP on halt detect or timeout.
  - STOP is held until rst.
  - start in RUN or STOP is ignored.
- RUN, every cycle:
  - cycle_cnt increments and saturates at all-ones.
  - prev_pc <= cur_pcout.
  - If cur_pcout == prev_pc, stall_cnt increments; otherwise stall_cnt <= 0.
  - Halt detect: stall_cnt == HALT_CYC-2 while cur_pcout == prev_pc. HALT_CYC equal PC samples in a row.
  - Timeout: MAX_CYC != 0 and cycle_cnt == MAX_CYC-1.
  - If halt and timeout fire in the same cycle, halt wins and timeout stays 0.
  - stop_en and timeout rise on the clock edge that enters STOP, one cycle after the triggering sample.
  - First cycle of RUN: prev_pc is not yet valid, so no stall comparison is made and stall_cnt <= 0.
- Logging:
  - Push condition: state RUN, reg_wen=1 and rd_adr != 0.
  - A push captures {cur_pcout, rd_adr, rddata} in the same edge.
  - Writes to x0 and writes outside RUN are never logged or counted.
  - Every push attempt increments retire_cnt, which saturates.
  - The cycle that triggers STOP is still logged if it qualifies.
- FIFO:
  - Show-ahead: the head entry is on trc_* whenever trc_valid=1.
  - Pop happens on trc_valid & trc_ready.
  - Empty with pop requested: no effect.
  - Full with push only: the entry is dropped and ovf <= 1 (sticky).
  - Full with push and pop in the same cycle: both happen, count unchanged, no ovf.
  - Empty with push: trc_valid rises the next cycle; no fall-through in the same cycle.
  - Pointers are log2(DEPTH) bits and wrap naturally; a separate count of log2(DEPTH)+1 bits gives full and empty.
  - Draining continues in STOP and IDLE.
- Reset mid-operation: all state clears immediately; undrained entries are lost.

Decomposition:
- Package rv32_mon_pkg:
  - mon_state_e enum {IDLE, RUN, STOP}.
  - trace_entry_t packed struct {pc[31:0], rd[4:0], data[31:0]}, 69 bits.
  - localparam XLEN=32.
- Sub-module rv32_trace_fifo (show-ahead synchronous FIFO):
  - Parameterised by DEPTH and entry type.
  - Ports: push, din, pop, dout, valid, full, count.
  - The top level holds the FSM, counters and halt/timeout logic.

Test Plan:
- Reset/idle: rst pulse; drive reg_wen=1, rd=5 without start -> trc_valid=0, retire_cnt=0, stop_en=0.
- Log and drain:
  - Stimulus: start; PCs 0,4,8; writes x1=10, x2=20, x0=99; trc_ready=1.
  - Required response: two entries {pc0,1,10}, {pc4,2,20}; x0 not logged; retire_cnt=2.
- Halt: after PC 0,4,8 hold PC=12 (jal x0,0) with HALT_CYC=4 -> stop_en rises exactly 4 cycles after PC first equals 12; timeout=0; later start ignored.
- Timeout: MAX_CYC=20, PC increments by 4 every cycle -> stop_en and timeout high after cycle_cnt reaches 20.
- Overflow and full push+pop:
  - DEPTH=4, trc_ready=0, six writes -> ovf=1, retire_cnt=6, drain yields first 4 entries.
  - Then refill to full, push with trc_ready=1 in the same cycle -> no additional drop and count stays 4.
- Reset mid-run: assert rst asynchronously with 3 entries queued and state RUN -> trc_valid, stop_en and counters drop to 0 without waiting for a clock edge.
